// File: rtl/dm_access_ctrl.sv
// -----------------------------------------------------------------------------
// dm_access_ctrl
// Load/store controller between the CPU MEM stage and a word-addressed data
// memory with a one-cycle synchronous read and a synchronous write.
// Byte/half/word loads and stores become word accesses; sub-word stores use a
// read-modify-write. Alignment is checked, loads are sign/zero-extended, and
// completion is reported through a req/done handshake.
//
// Optional feature macro: DAC_RANGE_CHECK_EN
//   defined   -> requests outside the BASE_ADDR window complete with an error
//   undefined -> no range check, upper address bits alias
//
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   cpu_req/cpu_we/cpu_size   request, store flag, access size (00 B, 01 H, 10 W)
//   cpu_sext                  load sign-extend select
//   cpu_addr/cpu_wdata        byte address, right-justified store data
//   cpu_ready                 high only while idle
//   cpu_done/cpu_err          one-cycle completion pulse and its error flag
//   cpu_rdata                 extended load result, held until the next load
//   dm_addr/dm_din            word address and write data to the memory
//   dm_memwrite/dm_memread    memory strobes
//   dm_dout                   memory read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module dm_access_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DM_AW     = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [1:0]       cpu_size,
    input  logic             cpu_sext,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    output logic             cpu_ready,
    output logic             cpu_done,
    output logic             cpu_err,
    output logic [31:0]      cpu_rdata,
    output logic [DM_AW-1:0] dm_addr,
    output logic [31:0]      dm_din,
    output logic             dm_memwrite,
    output logic             dm_memread,
    input  logic [31:0]      dm_dout
);

    typedef enum logic [2:0] {IDLE, READ, EXT, MERGE, WRITE, DONE} state_t;

    state_t           state, state_nxt;
    logic [DM_AW+1:0] addr_q;
    logic [31:0]      wdata_q;
    logic [1:0]       size_q;
    logic             we_q;
    logic             sext_q;
    logic             err_q;

    logic             misaligned;
    logic             range_err;
    logic             bad_req;
    logic [31:0]      lane_shift;
    logic [7:0]       lane_byte;
    logic [15:0]      lane_half;
    logic [31:0]      ext_data;
    logic [31:0]      merged;

    // Upper address bits only matter for the optional range check; folding
    // them here keeps the default build free of dangling inputs.
    logic unused_bits;
    assign unused_bits = ^{cpu_addr[31:DM_AW+2], BASE_ADDR};

    // Request classification on the live inputs, used only in IDLE.
    always_comb begin
        misaligned = 1'b0;
        range_err  = 1'b0;
        if (cpu_size == 2'b01 && cpu_addr[0])
            misaligned = 1'b1;
        if (cpu_size == 2'b10 && cpu_addr[1:0] != 2'b00)
            misaligned = 1'b1;
`ifdef DAC_RANGE_CHECK_EN
        range_err = (cpu_addr[31:DM_AW+2] != BASE_ADDR[31:DM_AW+2]);
`else
        range_err = 1'b0;
`endif
        bad_req = misaligned || (cpu_size == 2'b11) || range_err;
    end

    // Next-state logic; sub-word stores and all loads go through READ.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (bad_req)
                        state_nxt = DONE;
                    else if (cpu_we && cpu_size == 2'b10)
                        state_nxt = WRITE;
                    else
                        state_nxt = READ;
                end
            end
            READ:    state_nxt = we_q ? MERGE : EXT;
            EXT:     state_nxt = DONE;
            MERGE:   state_nxt = DONE;
            WRITE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Lane extraction and extension of the word returned by the memory.
    always_comb begin
        lane_shift = dm_dout >> {addr_q[1:0], 3'b000};
        lane_byte  = lane_shift[7:0];
        lane_half  = addr_q[1] ? dm_dout[31:16] : dm_dout[15:0];
        case (size_q)
            2'b00:   ext_data = {{24{sext_q & lane_byte[7]}}, lane_byte};
            2'b01:   ext_data = {{16{sext_q & lane_half[15]}}, lane_half};
            default: ext_data = dm_dout;
        endcase
    end

    // Read-modify-write: replace only the addressed lane(s) of the old word.
    always_comb begin
        merged = dm_dout;
        if (size_q == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else if (addr_q[1])
            merged[31:16] = wdata_q[15:0];
        else
            merged[15:0] = wdata_q[15:0];
    end

    // State register plus request capture and the held load result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= 2'b00;
            we_q      <= 1'b0;
            sext_q    <= 1'b0;
            err_q     <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && cpu_req) begin
                addr_q  <= cpu_addr[DM_AW+1:0];
                wdata_q <= cpu_wdata;
                size_q  <= cpu_size;
                we_q    <= cpu_we;
                sext_q  <= cpu_sext;
                err_q   <= bad_req;
            end
            if (state == EXT)
                cpu_rdata <= ext_data;
        end
    end

    // Outputs decode purely from registered state so a reset drops the
    // strobes immediately.
    always_comb begin
        cpu_ready   = (state == IDLE);
        cpu_done    = (state == DONE);
        cpu_err     = (state == DONE) && err_q;
        dm_memread  = (state == READ);
        dm_memwrite = (state == MERGE) || (state == WRITE);
        dm_addr     = addr_q[DM_AW+1:2];
        dm_din      = '0;
        if (state == WRITE)
            dm_din = wdata_q;
        else if (state == MERGE)
            dm_din = merged;
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dm_access_ctrl
// Directed self-checking bench for dm_access_ctrl with a behavioural
// 1024-word synchronous memory.
// -----------------------------------------------------------------------------
module tb_dm_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [1:0]  cpu_size;
    logic        cpu_sext;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_done;
    logic        cpu_err;
    logic [31:0] cpu_rdata;
    logic [9:0]  dm_addr;
    logic [31:0] dm_din;
    logic        dm_memwrite;
    logic        dm_memread;
    logic [31:0] dm_dout;

    logic [31:0] mem [0:1023];
    logic        tbWrEn;
    logic [9:0]  tbWrAddr;
    logic [31:0] tbWrData;

    int errors;
    int checks;
    int rdCount;
    int wrCount;
    int bothCount;

    dm_access_ctrl #(.BASE_ADDR(32'h0000_0000), .DM_AW(10)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_size    (cpu_size),
        .cpu_sext    (cpu_sext),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ready   (cpu_ready),
        .cpu_done    (cpu_done),
        .cpu_err     (cpu_err),
        .cpu_rdata   (cpu_rdata),
        .dm_addr     (dm_addr),
        .dm_din      (dm_din),
        .dm_memwrite (dm_memwrite),
        .dm_memread  (dm_memread),
        .dm_dout     (dm_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: registered read port, write port, bench preload port.
    always @(posedge clk) begin
        if (dm_memread)
            dm_dout <= mem[dm_addr];
        if (tbWrEn)
            mem[tbWrAddr] <= tbWrData;
        else if (dm_memwrite)
            mem[dm_addr] <= dm_din;
    end

    // Strobe activity counters, sampled mid-cycle.
    initial begin
        rdCount   = 0;
        wrCount   = 0;
        bothCount = 0;
    end
    always @(negedge clk) begin
        if (dm_memread)
            rdCount = rdCount + 1;
        if (dm_memwrite)
            wrCount = wrCount + 1;
        if (dm_memread && dm_memwrite)
            bothCount = bothCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        tbWrEn   = 1'b1;
        tbWrAddr = a;
        tbWrData = d;
        @(posedge clk);
        #1;
        tbWrEn = 1'b0;
    endtask

    // Issue one request, wait (bounded) for done, return latency and strobe counts.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sext,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output int lat, output int rds, output int wrs,
                                 output logic err);
        int r0;
        int w0;
        r0        = rdCount;
        w0        = wrCount;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_size  = size;
        cpu_sext  = sext;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        lat = 1;
        while (!cpu_done && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!cpu_done)
            lat = 99;
        err = cpu_err;
        @(posedge clk);
        #1;
        rds = rdCount - r0;
        wrs = wrCount - w0;
    endtask

    int          lat;
    int          rds;
    int          wrs;
    logic        err;
    logic [7:0]  doneMask;
    logic [31:0] lastRdata;

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_size  = 2'b00;
        cpu_sext  = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        tbWrEn    = 1'b0;
        tbWrAddr  = '0;
        tbWrData  = '0;
        dm_dout   = '0;

        // Reset values
        #1;
        checkOutput("rst_ready", {31'b0, cpu_ready}, 32'd1);
        checkOutput("rst_done", {31'b0, cpu_done}, 32'd0);
        checkOutput("rst_err", {31'b0, cpu_err}, 32'd0);
        checkOutput("rst_rdata", cpu_rdata, 32'h0);
        checkOutput("rst_strobes", {30'b0, dm_memread, dm_memwrite}, 32'd0);
        checkOutput("rst_dmaddr", {22'b0, dm_addr}, 32'd0);
        checkOutput("rst_dmdin", dm_din, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Word store
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, lat, rds, wrs, err);
        checkOutput("sw_lat", lat, 32'd2);
        checkOutput("sw_err", {31'b0, err}, 32'd0);
        checkOutput("sw_wr", wrs, 32'd1);
        checkOutput("sw_rd", rds, 32'd0);
        checkOutput("sw_mem", mem[4], 32'hDEADBEEF);

        // Loads
        preload(10'd4, 32'h8899AABB);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h013, 32'h0, lat, rds, wrs, err);
        checkOutput("lb3_lat", lat, 32'd3);
        checkOutput("lb3_data", cpu_rdata, 32'hFFFFFF88);
        checkOutput("lb3_acc", {rds[15:0], wrs[15:0]}, {16'd1, 16'd0});
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h011, 32'h0, lat, rds, wrs, err);
        checkOutput("lbu1_data", cpu_rdata, 32'h000000AA);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h012, 32'h0, lat, rds, wrs, err);
        checkOutput("lh2_data", cpu_rdata, 32'hFFFF8899);
        checkOutput("lh2_lat", lat, 32'd3);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h010, 32'h0, lat, rds, wrs, err);
        checkOutput("lhu0_data", cpu_rdata, 32'h0000AABB);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h010, 32'h0, lat, rds, wrs, err);
        checkOutput("lb0_data", cpu_rdata, 32'hFFFFFFBB);
        applyStimulus(1'b0, 2'b10, 1'b1, 32'h010, 32'h0, lat, rds, wrs, err);
        checkOutput("lw_data", cpu_rdata, 32'h8899AABB);
        checkOutput("lw_err", {31'b0, err}, 32'd0);

        // Sub-word stores (read-modify-write)
        preload(10'd4, 32'h11223344);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h012, 32'h000000EE, lat, rds, wrs, err);
        checkOutput("sb2_lat", lat, 32'd3);
        checkOutput("sb2_mem", mem[4], 32'h11EE3344);
        checkOutput("sb2_acc", {rds[15:0], wrs[15:0]}, {16'd1, 16'd1});
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h010, 32'h0000BEEF, lat, rds, wrs, err);
        checkOutput("sh0_mem", mem[4], 32'h11EEBEEF);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h013, 32'hFFFFFF55, lat, rds, wrs, err);
        checkOutput("sb3_mem", mem[4], 32'h55EEBEEF);
        checkOutput("rdata_held_store", cpu_rdata, 32'h8899AABB);

        // Error requests
        lastRdata = 32'h8899AABB;
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h006, 32'h0, lat, rds, wrs, err);
        checkOutput("lw_mis_lat", lat, 32'd1);
        checkOutput("lw_mis_err", {31'b0, err}, 32'd1);
        checkOutput("lw_mis_acc", {rds[15:0], wrs[15:0]}, 32'd0);
        checkOutput("lw_mis_rdata", cpu_rdata, lastRdata);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h011, 32'h1234, lat, rds, wrs, err);
        checkOutput("sh_mis_err", {31'b0, err}, 32'd1);
        checkOutput("sh_mis_acc", {rds[15:0], wrs[15:0]}, 32'd0);
        checkOutput("sh_mis_mem", mem[4], 32'h55EEBEEF);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h010, 32'h0, lat, rds, wrs, err);
        checkOutput("rsv_lat", lat, 32'd1);
        checkOutput("rsv_err", {31'b0, err}, 32'd1);
        checkOutput("rsv_rdata", cpu_rdata, lastRdata);

        // Upper address bits: alias by default, range error when checked
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h1010, 32'h0, lat, rds, wrs, err);
`ifdef DAC_RANGE_CHECK_EN
        checkOutput("range_err", {31'b0, err}, 32'd1);
        checkOutput("range_rdata", cpu_rdata, lastRdata);
`else
        checkOutput("alias_err", {31'b0, err}, 32'd0);
        checkOutput("alias_rdata", cpu_rdata, 32'h55EEBEEF);
`endif

        // Back-to-back with request held high
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_size  = 2'b10;
        cpu_sext  = 1'b0;
        cpu_addr  = 32'h010;
        doneMask  = '0;
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1;
            doneMask[i] = cpu_done;
            if (i < 7)
                @(posedge clk);
        end
        cpu_req = 1'b0;
        checkOutput("b2b_done", {24'b0, doneMask}, 32'h44);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("b2b_idle", {31'b0, cpu_ready}, 32'd1);

        // Reset during MERGE of a byte store
        preload(10'd4, 32'hCAFEF00D);
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_size  = 2'b00;
        cpu_addr  = 32'h010;
        cpu_wdata = 32'h00000077;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("merge_we", {31'b0, dm_memwrite}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstm_we", {31'b0, dm_memwrite}, 32'd0);
        checkOutput("rstm_ready", {31'b0, cpu_ready}, 32'd1);
        checkOutput("rstm_doneerr", {30'b0, cpu_done, cpu_err}, 32'd0);
        checkOutput("rstm_rdata", cpu_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rstm_mem", mem[4], 32'hCAFEF00D);
        checkOutput("rstm_ready2", {31'b0, cpu_ready}, 32'd1);

        checkOutput("strobe_excl", bothCount, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
